ecc_op_sequencer: RTL
=====================

# ecc_op_sequencer

Operation sequencer for the ECC encode/decode datapath. Accepts a start strobe from the APB register block and latches the CTRL, DATA_IN, CODEWORD_WIDTH and NOISE register values. Then drives the encoder and decoder through start/done handshakes, applying masked noise between them in full-channel mode. Returns the result, the decoder error count and a status code, with a one-cycle completion pulse.

## Interface
- AMBA_WORD, 32, register/data word width
- TIMEOUT_CYCLES, 64, max cycles spent in a wait state before abort (≥2)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle strobe issued on an APB write to CTRL
- CTRL  in  AMBA_WORD  bits[1:0] op: 00 encode, 01 decode, 10 full channel, 11 illegal
- DATA_IN  in  AMBA_WORD  operand
- CODEWORD_WIDTH  in  AMBA_WORD  bits[1:0]: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 illegal
- NOISE  in  AMBA_WORD  error pattern XORed onto the codeword in full-channel mode
- enc_start  out  1  one-cycle encoder launch
- enc_din  out  AMBA_WORD  encoder operand
- enc_done  in  1  encoder result valid
- enc_dout  in  AMBA_WORD  encoder codeword
- dec_start  out  1  one-cycle decoder launch
- dec_din  out  AMBA_WORD  decoder operand
- dec_done  in  1  decoder result valid
- dec_dout  in  AMBA_WORD  decoded data
- dec_nerr  in  2  errors detected by the decoder
- width_sel  out  2  latched CODEWORD_WIDTH[1:0], forwarded to both engines
- busy  out  1  operation in progress
- operation_done  out  1  one-cycle completion pulse
- data_out  out  AMBA_WORD  result
- num_of_errors  out  2  decoder error count (0 for encode-only)
- err_code  out  2  00 ok, 01 illegal op/width, 10 timeout

## Operation
- States: IDLE, ENC_REQ, ENC_WAIT, NOISE_APPLY, DEC_REQ, DEC_WAIT, DONE.
- IDLE + start:
  - Latch op, width, DATA_IN and NOISE into internal registers.
  - op = 11 or width = 11 → DONE, err_code = 01.
  - op 00/10 → ENC_REQ.
  - op 01 → DEC_REQ.
- start outside IDLE is ignored. Latched values do not change mid-operation.
- mask = 0xFF / 0xFFFF / all-ones for width 00 / 01 / 10.
- ENC_REQ:
  - enc_start = 1 for this cycle only.
  - enc_din = latched DATA_IN & mask.
  - Next state ENC_WAIT.
- ENC_WAIT:
  - On enc_done, capture enc_dout & mask into the codeword register.
  - op 00 → DONE. op 10 → NOISE_APPLY.
- NOISE_APPLY: one cycle; codeword ^= NOISE & mask; next state DEC_REQ.
- DEC_REQ:
  - dec_start = 1 for this cycle only.
  - dec_din = codeword (op 10) or DATA_IN & mask (op 01).
  - Next state DEC_WAIT.
- DEC_WAIT: on dec_done, capture dec_dout & mask and dec_nerr; next state DONE.
- Timeout:
  - A cycle counter clears on entry to each wait state and increments every wait cycle without done.
  - If counter = TIMEOUT_CYCLES−1 and done is low → DONE, err_code = 10, data_out = 0, num_of_errors = 0.
- data_out, num_of_errors and err_code are registered on the transition into DONE. They hold until the next transition into DONE.
- DONE: operation_done = 1; next state IDLE.
- enc_done/dec_done outside the matching wait state are ignored.
- enc_din/dec_din hold their last value outside the REQ states.

## Timing
- Reset: state IDLE; every output = 0, including busy, enc_start, dec_start, data_out, err_code and width_sel. All internal registers = 0.
- Reset mid-operation:
  - Aborts immediately.
  - No operation_done is issued.
  - start pulses are deasserted in the reset cycle's following edge.
- busy = 1 in every non-IDLE state, including DONE.
- Latency with start sampled at cycle T:
  - enc_start at T+1.
  - Earliest enc_done at T+2, giving DONE at T+3.
  - Encode with the done arriving k cycles after enc_start (k ≥ 1): operation_done at T+2+k.
  - Full channel: with 1-cycle engines, operation_done at T+6.
- Illegal op/width: operation_done at T+1.
- Back-to-back: a new start is accepted at T+4 at the earliest after a 1-cycle encode. A start in the DONE cycle is dropped.

## Test plan
- Encode: CTRL=0, width=00, DATA_IN=0x1234_565A; enc_done 3 cycles after enc_start with enc_dout=0xFFFF_FFA5.
  - Required: enc_din=0x5A, operation_done at T+5, data_out=0xA5, num_of_errors=0, err_code=00.
- Full channel: CTRL=2, width=01; enc_dout=0x1234; NOISE=0x0001_0001; dec_nerr=1, dec_dout=0x0034.
  - Required: dec_din=0x1235, data_out=0x0034, num_of_errors=1, operation_done at T+6 with 1-cycle engines.
- Illegal:
  - CTRL=3 → operation_done at T+1, err_code=01, no enc_start/dec_start.
  - Repeat with CTRL=0, width=11 → same response.
- Timeout: TIMEOUT_CYCLES=16, encoder never responds.
  - Required: operation_done at T+18, err_code=10, data_out=0.
  - A subsequent normal decode then completes with err_code=00.
- start pulsed again during ENC_WAIT, and in the DONE cycle → ignored; exactly one enc_start per accepted start.
- rst asserted during DEC_WAIT → next cycle all outputs 0 and IDLE; a late dec_done is ignored; a fresh start then runs normally.

Source files
------------

// File: rtl/ecc_op_sequencer.sv
// ecc_op_sequencer: sequences encoder, noise and decoder steps for one ECC operation per start strobe
//   clk, rst                        clock and synchronous active-high reset
//   start, CTRL, DATA_IN,
//   CODEWORD_WIDTH, NOISE           operation request and its operands from the register block
//   enc_start/enc_din/enc_done/enc_dout                     encoder handshake
//   dec_start/dec_din/dec_done/dec_dout/dec_nerr            decoder handshake
//   width_sel                       latched codeword width, shared by both engines
//   busy, operation_done, data_out,
//   num_of_errors, err_code         status and result
module ecc_op_sequencer #(
  parameter int AMBA_WORD = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AMBA_WORD-1:0] CTRL,
  input  logic [AMBA_WORD-1:0] DATA_IN,
  input  logic [AMBA_WORD-1:0] CODEWORD_WIDTH,
  input  logic [AMBA_WORD-1:0] NOISE,
  output logic                 enc_start,
  output logic [AMBA_WORD-1:0] enc_din,
  input  logic                 enc_done,
  input  logic [AMBA_WORD-1:0] enc_dout,
  output logic                 dec_start,
  output logic [AMBA_WORD-1:0] dec_din,
  input  logic                 dec_done,
  input  logic [AMBA_WORD-1:0] dec_dout,
  input  logic [1:0]           dec_nerr,
  output logic [1:0]           width_sel,
  output logic                 busy,
  output logic                 operation_done,
  output logic [AMBA_WORD-1:0] data_out,
  output logic [1:0]           num_of_errors,
  output logic [1:0]           err_code
);
  typedef enum logic [2:0] {IDLE, ENC_REQ, ENC_WAIT, NOISE_APPLY, DEC_REQ, DEC_WAIT, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] ERR_OK = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  function automatic logic [AMBA_WORD-1:0] mask_of(input logic [1:0] w);
    return w == 2'b00 ? AMBA_WORD'(32'hFF) : w == 2'b01 ? AMBA_WORD'(32'hFFFF) : {AMBA_WORD{1'b1}};
  endfunction
  state_t state;
  logic [1:0] op;
  logic [AMBA_WORD-1:0] noise_q;
  logic [AMBA_WORD-1:0] code;
  logic [CW-1:0] cnt;
  logic [AMBA_WORD-1:0] mask;
  logic [AMBA_WORD-1:0] noisy;
  logic illegal_in;
  logic unused_hi;
  assign mask = mask_of(width_sel);
  assign noisy = code ^ (noise_q & mask);
  assign illegal_in = CTRL[1:0] == 2'b11 || CODEWORD_WIDTH[1:0] == 2'b11;
  assign unused_hi = ^{CTRL[AMBA_WORD-1:2], CODEWORD_WIDTH[AMBA_WORD-1:2]};
  // The masked operand is captured straight into enc_din/dec_din at start, so
  // those registers double as the latched DATA_IN and hold outside the REQ states.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op <= '0;
      width_sel <= '0;
      noise_q <= '0;
      code <= '0;
      cnt <= '0;
      enc_start <= 1'b0;
      enc_din <= '0;
      dec_start <= 1'b0;
      dec_din <= '0;
      busy <= 1'b0;
      operation_done <= 1'b0;
      data_out <= '0;
      num_of_errors <= '0;
      err_code <= '0;
    end else begin
      enc_start <= 1'b0;
      dec_start <= 1'b0;
      operation_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op <= CTRL[1:0];
          width_sel <= CODEWORD_WIDTH[1:0];
          noise_q <= NOISE;
          busy <= 1'b1;
          if (illegal_in) begin
            state <= DONE;
            operation_done <= 1'b1;
            data_out <= '0;
            num_of_errors <= '0;
            err_code <= ERR_ILLEGAL;
          end else if (CTRL[1:0] == 2'b01) begin
            state <= DEC_REQ;
            dec_start <= 1'b1;
            dec_din <= DATA_IN & mask_of(CODEWORD_WIDTH[1:0]);
          end else begin
            state <= ENC_REQ;
            enc_start <= 1'b1;
            enc_din <= DATA_IN & mask_of(CODEWORD_WIDTH[1:0]);
          end
        end
        ENC_REQ: begin
          state <= ENC_WAIT;
          cnt <= '0;
        end
        ENC_WAIT: if (enc_done) begin
          code <= enc_dout & mask;
          if (op == 2'b00) begin
            state <= DONE;
            operation_done <= 1'b1;
            data_out <= enc_dout & mask;
            num_of_errors <= '0;
            err_code <= ERR_OK;
          end else begin
            state <= NOISE_APPLY;
          end
        end else if (cnt == LAST) begin
          state <= DONE;
          operation_done <= 1'b1;
          data_out <= '0;
          num_of_errors <= '0;
          err_code <= ERR_TIMEOUT;
        end else begin
          cnt <= cnt + 1'b1;
        end
        // Noise lands in the codeword and the decoder operand on the same edge
        // that raises dec_start, so DEC_REQ presents the corrupted word.
        NOISE_APPLY: begin
          state <= DEC_REQ;
          code <= noisy;
          dec_din <= noisy;
          dec_start <= 1'b1;
        end
        DEC_REQ: begin
          state <= DEC_WAIT;
          cnt <= '0;
        end
        DEC_WAIT: if (dec_done) begin
          state <= DONE;
          operation_done <= 1'b1;
          data_out <= dec_dout & mask;
          num_of_errors <= dec_nerr;
          err_code <= ERR_OK;
        end else if (cnt == LAST) begin
          state <= DONE;
          operation_done <= 1'b1;
          data_out <= '0;
          num_of_errors <= '0;
          err_code <= ERR_TIMEOUT;
        end else begin
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
